// File: rtl/amm_mem_responder.sv
// amm_mem_responder
//   Avalon-MM slave memory model. Accepts single and burst reads/writes with
//   byte enables into a word-addressed RAM, returns read data through a
//   fixed-latency in-order pipeline and flags master protocol violations.
//
// Optional feature macro: AMM_RESP_RND_WAIT_EN
//   When defined, a 16-bit LFSR injects pseudo-random waitrequest stalls
//   (about 25 %) in IDLE/WR_BURST and pauses read beat issue in RD_BURST.
//   When undefined, waitrequest_o is high only while a read burst issues.
//
// Ports:
//   clk_i            clock
//   rst_i            asynchronous active-low reset
//   address_i        byte address; word index = address_i[BYTE_ADDR_W +: MEM_ADDR_W]
//   read_i           read request
//   write_i          write request / write beat
//   writedata_i      write data
//   burstcount_i     burst length in words (0 is treated as 1 and flagged)
//   byteenable_i     per-byte write enable
//   waitrequest_o    slave stall
//   readdata_o       read data
//   readdatavalid_o  readdata_o valid
//   err_clr_i        clears proto_err_o
//   proto_err_o      sticky protocol-violation flag
//
// FSM states:
//   IDLE     | waiting for a command
//   WR_BURST | accepting the remaining beats of a write burst
//   RD_BURST | issuing one read beat per (unstalled) cycle
module amm_mem_responder #(
  parameter int AMM_ADDR_W   = 32,
  parameter int AMM_DATA_W   = 64,
  parameter int AMM_BURST_W  = 11,
  parameter int MEM_ADDR_W   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [AMM_ADDR_W-1:0]   address_i,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic [AMM_DATA_W-1:0]   writedata_i,
  input  logic [AMM_BURST_W-1:0]  burstcount_i,
  input  logic [AMM_DATA_W/8-1:0] byteenable_i,
  output logic                    waitrequest_o,
  output logic [AMM_DATA_W-1:0]   readdata_o,
  output logic                    readdatavalid_o,
  input  logic                    err_clr_i,
  output logic                    proto_err_o
);

  localparam int BYTE_PER_WORD = AMM_DATA_W / 8;
  localparam int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD);
  localparam int DEPTH         = 2 ** MEM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [MEM_ADDR_W-1:0]   next_addr, next_addr_nxt;
  logic [AMM_BURST_W-1:0]  beats_left, beats_left_nxt;

  logic                    stall;
  logic                    mem_we;
  logic [MEM_ADDR_W-1:0]   mem_waddr;
  logic                    rd_issue;
  logic                    err_set;

  logic [AMM_DATA_W-1:0]   mem [DEPTH];

  // Command decode. Address bits above the RAM index are deliberately ignored.
  logic [MEM_ADDR_W-1:0]   cmd_word;
  logic                    cmd_misalign;
  logic                    cmd_zero;
  logic [AMM_BURST_W-1:0]  cmd_len;
  logic                    addr_hi_unused;

  assign cmd_word       = address_i[BYTE_ADDR_W +: MEM_ADDR_W];
  assign cmd_misalign   = |address_i[BYTE_ADDR_W-1:0];
  assign cmd_zero       = (burstcount_i == '0);
  assign cmd_len        = cmd_zero ? AMM_BURST_W'(1) : burstcount_i;
  assign addr_hi_unused = ^address_i[AMM_ADDR_W-1:BYTE_ADDR_W+MEM_ADDR_W];

`ifdef AMM_RESP_RND_WAIT_EN
  // Fibonacci LFSR, taps for x^16 + x^14 + x^13 + x^11 + 1.
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      next_addr  <= '0;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      next_addr  <= next_addr_nxt;
      beats_left <= beats_left_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt      = state;
    next_addr_nxt  = next_addr;
    beats_left_nxt = beats_left;
    mem_we         = 1'b0;
    mem_waddr      = next_addr;
    rd_issue       = 1'b0;
    err_set        = 1'b0;
    waitrequest_o  = stall;

    case (state)
      IDLE: begin
        if (!stall) begin
          if (write_i) begin
            // Write wins over a simultaneous read; the read is dropped.
            mem_we    = 1'b1;
            mem_waddr = cmd_word;
            err_set   = read_i | cmd_misalign | cmd_zero;
            if (cmd_len > AMM_BURST_W'(1)) begin
              state_nxt      = WR_BURST;
              beats_left_nxt = cmd_len - AMM_BURST_W'(1);
              next_addr_nxt  = cmd_word + MEM_ADDR_W'(1);
            end
          end else if (read_i) begin
            err_set        = cmd_misalign | cmd_zero;
            state_nxt      = RD_BURST;
            beats_left_nxt = cmd_len;
            next_addr_nxt  = cmd_word;
          end
        end
      end

      WR_BURST: begin
        err_set = read_i;
        if (!stall && write_i) begin
          mem_we         = 1'b1;
          next_addr_nxt  = next_addr + MEM_ADDR_W'(1);
          beats_left_nxt = beats_left - AMM_BURST_W'(1);
          if (beats_left == AMM_BURST_W'(1)) begin
            state_nxt = IDLE;
          end
        end
      end

      RD_BURST: begin
        waitrequest_o = 1'b1;
        if (!stall) begin
          rd_issue       = 1'b1;
          next_addr_nxt  = next_addr + MEM_ADDR_W'(1);
          beats_left_nxt = beats_left - AMM_BURST_W'(1);
          if (beats_left == AMM_BURST_W'(1)) begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // RAM write port with byte enables; contents survive reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BYTE_PER_WORD; b++) begin
      if (mem_we && byteenable_i[b]) begin
        mem[mem_waddr][b*8 +: 8] <= writedata_i[b*8 +: 8];
      end
    end
  end

  // Read pipeline: stage 0 samples the RAM on issue, each further stage adds
  // one cycle, so data emerges READ_LATENCY cycles after the issue cycle.
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [AMM_DATA_W-1:0]   pipe_dat [READ_LATENCY];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_issue;
      if (rd_issue) begin
        pipe_dat[0] <= mem[next_addr];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign readdata_o      = pipe_dat[READ_LATENCY-1];
  assign readdatavalid_o = pipe_vld[READ_LATENCY-1];

  // Sticky error flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      proto_err_o <= 1'b0;
    end else if (err_set) begin
      proto_err_o <= 1'b1;
    end else if (err_clr_i) begin
      proto_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amm_mem_responder.sv
// Testbench for amm_mem_responder (default build, READ_LATENCY = 2).
module tb_amm_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] address_i = '0;
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic [63:0] writedata_i = '0;
  logic [10:0] burstcount_i = '0;
  logic [7:0]  byteenable_i = '0;
  logic        waitrequest_o;
  logic [63:0] readdata_o;
  logic        readdatavalid_o;
  logic        err_clr_i = 1'b0;
  logic        proto_err_o;

  amm_mem_responder dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .address_i       (address_i),
    .read_i          (read_i),
    .write_i         (write_i),
    .writedata_i     (writedata_i),
    .burstcount_i    (burstcount_i),
    .byteenable_i    (byteenable_i),
    .waitrequest_o   (waitrequest_o),
    .readdata_o      (readdata_o),
    .readdatavalid_o (readdatavalid_o),
    .err_clr_i       (err_clr_i),
    .proto_err_o     (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: memory image plus queue of expected responses.
  typedef struct {
    logic [63:0] d;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] rx_log[$];
  logic [63:0] mm [DEPTH];
  logic [63:0] wd [DEPTH];
  logic [7:0]  wb [DEPTH];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rx(input int k);
    if (k < rx_log.size()) return rx_log[k];
    return 'x;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Every readdatavalid must match the next expected response, in order and
  // in the cycle the fixed latency dictates.
  always @(negedge clk_i) begin
    if (rst_i && readdatavalid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rdv", 64'(readdata_o), 64'hDEAD_0000_0000_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", readdata_o, e.d);
        chk("rd_cycle", 64'(cyc), 64'(e.c));
      end
      rx_log.push_back(readdata_o);
    end
  end

  // Present one request and hold it until accepted; t = accept cycle.
  task automatic send(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [10:0] bc, input logic [63:0] d,
                      input logic [7:0] be, output int t);
    int g;
    read_i = rd; write_i = wr; address_i = a; burstcount_i = bc;
    writedata_i = d; byteenable_i = be;
    g = 0;
    while (waitrequest_o) begin
      @(posedge clk_i); #1;
      g++;
      if (g > 200) begin
        chk("accept_timeout", 64'(g), 64'd0);
        break;
      end
    end
    t = cyc;
    @(posedge clk_i); #1;
    read_i = 1'b0; write_i = 1'b0;
  endtask

  // Write burst from wd/wb; n==0 sends burstcount 0 (one beat).
  // rd_beat marks a beat that also raises read_i; lo sets low address bits.
  task automatic wr_burst(input int w, input int n, input int rd_beat, input logic [2:0] lo);
    int beats, t;
    logic [31:0] a;
    logic [10:0] bc;
    beats = (n == 0) ? 1 : n;
    for (int k = 0; k < beats; k++) begin
      if (k == 0) begin
        a  = 32'((w % DEPTH) * 8) | 32'(lo);
        bc = 11'(n);
      end else begin
        a  = $urandom;
        bc = 11'($urandom);
      end
      send(k == rd_beat, 1'b1, a, bc, wd[k], wb[k], t);
      mm[(w + k) % DEPTH] = merge(mm[(w + k) % DEPTH], wd[k], wb[k]);
    end
  endtask

  task automatic rd_burst(input int w, input int n, output int t);
    send(1'b1, 1'b0, 32'((w % DEPTH) * 8), 11'(n), 64'd0, 8'd0, t);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.d = mm[(w + k) % DEPTH];
      e.c = t + 1 + k + LAT;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk_i); #1;
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_err();
    err_clr_i = 1'b1;
    @(posedge clk_i); #1;
    err_clr_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, t2;
    logic [63:0] keep;

    // Reset values
    #2;
    chk("rst_wait", 64'(waitrequest_o), 64'd0);
    chk("rst_rdv", 64'(readdatavalid_o), 64'd0);
    chk("rst_rdata", readdata_o, 64'd0);
    chk("rst_err", 64'(proto_err_o), 64'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Fill the whole RAM with one long burst so the model is fully known.
    for (int k = 0; k < DEPTH; k++) begin
      wd[k] = rnd64();
      wb[k] = 8'hFF;
    end
    wr_burst(0, DEPTH, -1, 3'd0);
    chk("fill_err", 64'(proto_err_o), 64'd0);

    // Single write / single read
    wd[0] = 64'h1122334455667788; wb[0] = 8'hFF;
    wr_burst(8, 1, -1, 3'd0);
    rx_log.delete();
    rd_burst(8, 1, t);
    chk("single_wait_hi", 64'(waitrequest_o), 64'd1);
    @(posedge clk_i); #1;
    chk("single_wait_lo", 64'(waitrequest_o), 64'd0);
    wait_drain();
    chk("single_data", rx(0), 64'h1122334455667788);

    // Byte-enabled burst over a preloaded word
    wd[0] = '1; wb[0] = 8'hFF;
    wr_burst(32, 1, -1, 3'd0);
    for (int k = 0; k < 4; k++) begin
      wd[k] = 64'(8'hA0 + k);
      wb[k] = (k == 0) ? 8'h0F : 8'hFF;
    end
    wr_burst(32, 4, -1, 3'd0);
    rx_log.delete();
    rd_burst(32, 4, t);
    wait_drain();
    chk("be_beat0", rx(0), 64'hFFFFFFFF000000A0);
    chk("be_beat1", rx(1), 64'h00000000000000A1);
    chk("be_beat2", rx(2), 64'h00000000000000A2);
    chk("be_beat3", rx(3), 64'h00000000000000A3);

    // Wrap past the top word
    for (int k = 0; k < 3; k++) begin
      wd[k] = rnd64(); wb[k] = 8'hFF;
    end
    keep = wd[1];
    wr_burst(1023, 3, -1, 3'd0);
    rx_log.delete();
    rd_burst(0, 1, t);
    wait_drain();
    chk("wrap_word0", rx(0), keep);
    rd_burst(1023, 3, t);
    wait_drain();

    // Simultaneous read and write in IDLE: write wins, read dropped
    wd[0] = rnd64(); wb[0] = 8'hFF;
    wr_burst(50, 1, 0, 3'd0);
    chk("rw_err_set", 64'(proto_err_o), 64'd1);
    repeat (5) @(posedge clk_i);
    #1;
    clear_err();
    chk("rw_err_clr", 64'(proto_err_o), 64'd0);
    rd_burst(50, 1, t);
    wait_drain();

    // Burstcount 0 writes exactly one beat
    wd[0] = rnd64(); wb[0] = 8'hFF;
    wd[1] = rnd64(); wb[1] = 8'hFF;
    wr_burst(60, 0, -1, 3'd0);
    chk("bc0_err", 64'(proto_err_o), 64'd1);
    clear_err();
    rd_burst(60, 2, t);
    wait_drain();

    // Misaligned command with a concurrent clear: set wins
    wd[0] = rnd64(); wb[0] = 8'hFF;
    err_clr_i = 1'b1;
    wr_burst(70, 1, -1, 3'd5);
    err_clr_i = 1'b0;
    chk("misalign_set_wins", 64'(proto_err_o), 64'd1);
    clear_err();
    chk("misalign_clr", 64'(proto_err_o), 64'd0);
    rd_burst(70, 1, t);
    wait_drain();

    // read_i during a write burst: flagged, beat still written
    for (int k = 0; k < 3; k++) begin
      wd[k] = rnd64(); wb[k] = 8'hFF;
    end
    wr_burst(80, 3, 1, 3'd0);
    chk("rd_in_wr_err", 64'(proto_err_o), 64'd1);
    clear_err();
    rd_burst(80, 3, t);
    wait_drain();

    // Back-to-back reads
    rd_burst(100, 2, t);
    rd_burst(110, 1, t2);
    chk("b2b_accept", 64'(t2 - t), 64'd3);
    wait_drain();

    // Reset in the middle of an 8-beat read
    rd_burst(200, 8, t);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_wait", 64'(waitrequest_o), 64'd0);
    chk("rst_mid_rdv", 64'(readdatavalid_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (12) @(posedge clk_i);
    #1;
    chk("rst_after_wait", 64'(waitrequest_o), 64'd0);
    rd_burst(200, 8, t);
    wait_drain();

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      int w, n;
      w = int'($urandom_range(DEPTH - 1, 0));
      n = int'($urandom_range(8, 1));
      if ($urandom_range(1, 0) == 1) begin
        for (int k = 0; k < n; k++) begin
          wd[k] = rnd64();
          wb[k] = 8'($urandom);
        end
        wr_burst(w, n, -1, 3'd0);
      end else begin
        rd_burst(w, n, t);
      end
      chk("rand_err", 64'(proto_err_o), 64'd0);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
